// File: rtl/router_pkg.sv
// Shared constants and the address decode helper for the 1x3 router.
package router_pkg;

   localparam int ROUTER_NUM_CH       = 3;
   localparam int ROUTER_ADDR_W       = 2;
   localparam int ROUTER_SYNC_TIMEOUT = 30;
   localparam int ROUTER_SYNC_CNT_W   = 5;

   typedef logic [ROUTER_ADDR_W-1:0] router_addr_t;

   localparam router_addr_t ROUTER_ADDR_INVALID = 2'b11;

   // The invalid address maps to no channel, so its packet is silently dropped.
   function automatic logic [ROUTER_NUM_CH-1:0] addr_to_onehot(input router_addr_t addr);
      logic [ROUTER_NUM_CH-1:0] onehot;
      case (addr)
         2'b00:   onehot = 3'b001;
         2'b01:   onehot = 3'b010;
         2'b10:   onehot = 3'b100;
         default: onehot = 3'b000;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel watchdog: pulses soft_rst when valid data sits unread for TIMEOUT
// consecutive cycles.
module router_sync_timer #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic clock,
   input  logic resetn,
   input  logic vld,
   input  logic rd,
   output logic soft_rst
);

   logic [CNT_W-1:0] cnt;

   // Any read or idle cycle restarts the window; the counter clears on the pulse
   // itself so it never wraps.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         cnt      <= '0;
         soft_rst <= 1'b0;
      end else if (vld && !rd) begin
         if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt      <= '0;
            soft_rst <= 1'b1;
         end else begin
            cnt      <= cnt + CNT_W'(1);
            soft_rst <= 1'b0;
         end
      end else begin
         cnt      <= '0;
         soft_rst <= 1'b0;
      end
   end

endmodule

// File: rtl/router_sync.sv
// Router address/handshake synchroniser: address latch, write steering, full mux and
// per-channel timeouts. Optional sticky timeout status under ROUTER_SYNC_TO_STATUS_EN.
module router_sync
   import router_pkg::*;
#(
   parameter int TIMEOUT = ROUTER_SYNC_TIMEOUT,
   parameter int CNT_W   = ROUTER_SYNC_CNT_W
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     detect_add,
   input  logic [ROUTER_ADDR_W-1:0] data_in,
   input  logic                     write_enb_reg,
   input  logic [ROUTER_NUM_CH-1:0] read_enb,
   input  logic [ROUTER_NUM_CH-1:0] empty,
   input  logic [ROUTER_NUM_CH-1:0] full,
`ifdef ROUTER_SYNC_TO_STATUS_EN
   input  logic                     clr_status,
   output logic [ROUTER_NUM_CH-1:0] timeout_flag,
`endif
   output logic [ROUTER_NUM_CH-1:0] write_enb,
   output logic                     fifo_full,
   output logic [ROUTER_NUM_CH-1:0] vld_out,
   output logic [ROUTER_NUM_CH-1:0] soft_reset
);

   router_addr_t int_addr;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         int_addr <= '0;
      end else if (detect_add) begin
         int_addr <= data_in;
      end
   end

   // Decode uses the registered address, so a header written in the same cycle it is
   // detected still goes to the previously latched channel.
   always_comb begin
      write_enb = '0;
      if (write_enb_reg) begin
         write_enb = addr_to_onehot(int_addr);
      end
   end

   always_comb begin
      fifo_full = 1'b0;
      case (int_addr)
         2'b00:   fifo_full = full[0];
         2'b01:   fifo_full = full[1];
         2'b10:   fifo_full = full[2];
         default: fifo_full = 1'b0;
      endcase
   end

   assign vld_out = ~empty;

   for (genvar ch = 0; ch < ROUTER_NUM_CH; ch++) begin : g_timer
      router_sync_timer #(
         .TIMEOUT (TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_timer (
         .clock    (clock),
         .resetn   (resetn),
         .vld      (vld_out[ch]),
         .rd       (read_enb[ch]),
         .soft_rst (soft_reset[ch])
      );
   end

`ifdef ROUTER_SYNC_TO_STATUS_EN
   // A timeout landing in the same cycle as a clear must not be lost, so set wins.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         timeout_flag <= '0;
      end else begin
         timeout_flag <= (timeout_flag & ~{ROUTER_NUM_CH{clr_status}}) | soft_reset;
      end
   end
`endif

endmodule

// File: tb/tb_router_sync.sv
// Directed bench for router_sync with a queue of expected values; covers the
// timeout status flags when ROUTER_SYNC_TO_STATUS_EN is defined.
module tb_router_sync;

   logic       clock;
   logic       resetn;
   logic       detect_add;
   logic [1:0] data_in;
   logic       write_enb_reg;
   logic [2:0] read_enb;
   logic [2:0] empty;
   logic [2:0] full;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic [2:0] vld_out;
   logic [2:0] soft_reset;
`ifdef ROUTER_SYNC_TO_STATUS_EN
   logic       clr_status;
   logic [2:0] timeout_flag;
`endif

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   router_sync dut (
      .clock         (clock),
      .resetn        (resetn),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .write_enb_reg (write_enb_reg),
      .read_enb      (read_enb),
      .empty         (empty),
      .full          (full),
`ifdef ROUTER_SYNC_TO_STATUS_EN
      .clr_status    (clr_status),
      .timeout_flag  (timeout_flag),
`endif
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out       (vld_out),
      .soft_reset    (soft_reset)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic applyStimulus(input logic de, input logic [1:0] din, input logic we,
                                input logic [2:0] rd, input logic [2:0] emp,
                                input logic [2:0] fl);
      detect_add    = de;
      data_in       = din;
      write_enb_reg = we;
      read_enb      = rd;
      empty         = emp;
      full          = fl;
      #1;
   endtask

   task automatic expectVal(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input logic [7:0] obs);
      exp_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $error("[TB] FAIL scoreboard_empty: observed %0h with nothing expected", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      logic [2:0] fl;
      vectors     = 0;
      miscompares = 0;
      resetn      = 1'b0;
`ifdef ROUTER_SYNC_TO_STATUS_EN
      clr_status  = 1'b0;
`endif
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
      #12;

      // Reset state and combinational pass-through
      expectVal("rst_soft_reset", 8'h00); checkOutput({5'b0, soft_reset});
      expectVal("rst_vld_out", 8'h00);    checkOutput({5'b0, vld_out});
      expectVal("rst_write_enb", 8'h00);  checkOutput({5'b0, write_enb});
`ifdef ROUTER_SYNC_TO_STATUS_EN
      expectVal("rst_timeout_flag", 8'h00); checkOutput({5'b0, timeout_flag});
`endif
      applyStimulus(1'b0, 2'b00, 1'b1, 3'b000, 3'b010, 3'b000);
      expectVal("rst_vld_follow", 8'h05);  checkOutput({5'b0, vld_out});
      expectVal("rst_write_addr0", 8'h01); checkOutput({5'b0, write_enb});

      @(negedge clock);
      resetn = 1'b1;
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);

      // Test 1: latch address 01 then write for 12 cycles
      applyStimulus(1'b1, 2'b01, 1'b0, 3'b000, 3'b111, 3'b000);
      tick();
      for (int i = 0; i < 12; i++) begin
         fl = 3'(i);
         applyStimulus(1'b0, 2'b00, 1'b1, 3'b000, 3'b111, fl);
         expectVal("t1_write_enb", 8'h02);       checkOutput({5'b0, write_enb});
         expectVal("t1_fifo_full", {7'b0, fl[1]}); checkOutput({7'b0, fifo_full});
         tick();
      end

      // Header and write in the same cycle use the previous address
      applyStimulus(1'b1, 2'b10, 1'b1, 3'b000, 3'b111, 3'b000);
      expectVal("same_cycle_old_addr", 8'h02); checkOutput({5'b0, write_enb});
      tick();
      applyStimulus(1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b100);
      expectVal("addr2_write_enb", 8'h04); checkOutput({5'b0, write_enb});
      expectVal("addr2_fifo_full", 8'h01); checkOutput({7'b0, fifo_full});

      // Test 2: invalid address drops the packet
      applyStimulus(1'b1, 2'b11, 1'b0, 3'b000, 3'b111, 3'b000);
      tick();
      applyStimulus(1'b0, 2'b00, 1'b1, 3'b000, 3'b111, 3'b111);
      expectVal("t2_write_enb", 8'h00); checkOutput({5'b0, write_enb});
      expectVal("t2_fifo_full", 8'h00); checkOutput({7'b0, fifo_full});
      tick();

      // Test 3: channel 0 unread, pulse on the 30th edge only
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b110, 3'b000);
      expectVal("t3_vld_out", 8'h01); checkOutput({5'b0, vld_out});
      for (int k = 1; k <= 31; k++) begin
         tick();
         expectVal($sformatf("t3_soft_edge%0d", k), (k == 30) ? 8'h01 : 8'h00);
         checkOutput({5'b0, soft_reset});
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
      tick();

      // Test 4: a read on edge 29 restarts the window, pulse moves to edge 59
      for (int k = 1; k <= 60; k++) begin
         applyStimulus(1'b0, 2'b00, 1'b0, (k == 29) ? 3'b100 : 3'b000, 3'b011, 3'b000);
         tick();
         expectVal($sformatf("t4_soft_edge%0d", k), (k == 59) ? 8'h04 : 8'h00);
         checkOutput({5'b0, soft_reset});
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b111, 3'b000);
      tick();

      // Test 5: reset in mid-count on channel 1
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b101, 3'b000);
      for (int k = 1; k <= 20; k++) tick();
      expectVal("t5_pre_reset_soft", 8'h00); checkOutput({5'b0, soft_reset});
      resetn = 1'b0;
      #1;
      expectVal("t5_in_reset_soft", 8'h00); checkOutput({5'b0, soft_reset});
      applyStimulus(1'b0, 2'b00, 1'b1, 3'b000, 3'b101, 3'b000);
      expectVal("t5_addr_cleared", 8'h01); checkOutput({5'b0, write_enb});
      applyStimulus(1'b0, 2'b00, 1'b0, 3'b000, 3'b101, 3'b000);
      tick();
      resetn = 1'b1;
      for (int k = 1; k <= 61; k++) begin
`ifdef ROUTER_SYNC_TO_STATUS_EN
         clr_status = (k == 32) || (k == 61);
`endif
         tick();
         expectVal($sformatf("t5_soft_edge%0d", k), (k == 30 || k == 60) ? 8'h02 : 8'h00);
         checkOutput({5'b0, soft_reset});
`ifdef ROUTER_SYNC_TO_STATUS_EN
         // Test 6: sticky flag, cleared by clr_status, set beats clear
         expectVal($sformatf("t6_flag_edge%0d", k),
                   (k == 31 || k == 61) ? 8'h02 : 8'h00);
         checkOutput({5'b0, timeout_flag});
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
